// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters (lookups_o, hits_o) are built when BTB_STATS_EN is defined.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_i,
    input  logic        lookup_en_i,
    output logic [31:0] npc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        flush_i
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] lookups_o,
    output logic [31:0] hits_o
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic            valid_reg  [ENTRIES];
    logic [TAGW-1:0] tag_reg    [ENTRIES];
    logic [31:0]     target_reg [ENTRIES];
    logic [1:0]      ctr_reg    [ENTRIES];

    logic [IDXW-1:0] look_idx;
    logic [TAGW-1:0] look_tag;
    logic            look_hit;
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;

    assign look_idx = pc_i[IDXW+1:2];
    assign look_tag = pc_i[31:IDXW+2];
    assign look_hit = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);

    assign upd_idx  = upd_pc_i[IDXW+1:2];
    assign upd_tag  = upd_pc_i[31:IDXW+2];
    assign upd_hit  = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    // Purely combinational prediction; reset clears valid bits so outputs fall back to pc+4.
    always_comb begin
        pred_taken_o  = look_hit && ctr_reg[look_idx][1];
        pred_target_o = look_hit ? target_reg[look_idx] : 32'd0;
        npc_o         = pred_taken_o ? pred_target_o : (pc_i + 32'd4);
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic sel;
            assign sel = upd_valid_i && (upd_idx == IDXW'(gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= 32'd0;
                    ctr_reg[gi]    <= 2'b01;
                end else if (flush_i) begin
                    // Flush wins over any same-cycle update; only valid bits are cleared.
                    valid_reg[gi] <= 1'b0;
                end else if (sel) begin
                    if (upd_hit) begin
                        if (upd_taken_i) begin
                            target_reg[gi] <= upd_target_i;
                            if (ctr_reg[gi] != 2'b11) ctr_reg[gi] <= ctr_reg[gi] + 2'b01;
                        end else if (ctr_reg[gi] != 2'b00) begin
                            ctr_reg[gi] <= ctr_reg[gi] - 2'b01;
                        end
                    end else if (upd_taken_i) begin
                        valid_reg[gi]  <= 1'b1;
                        tag_reg[gi]    <= upd_tag;
                        target_reg[gi] <= upd_target_i;
                        ctr_reg[gi]    <= 2'b10;
                    end
                end
            end
        end
    endgenerate

`ifdef BTB_STATS_EN
    logic [31:0] lookups_reg;
    logic [31:0] hits_reg;

    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lookups_reg <= 32'd0;
            hits_reg    <= 32'd0;
        end else if (lookup_en_i) begin
            lookups_reg <= lookups_reg + 32'd1;
            if (look_hit) hits_reg <= hits_reg + 32'd1;
        end
    end

    assign lookups_o = lookups_reg;
    assign hits_o    = hits_reg;

    logic unused_bits;
    assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0], lookup_en_i};
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a driver pushes model predictions,
// a monitor pops and compares them against the DUT each cycle.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int IDXW    = $clog2(ENTRIES);

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        lookup_en_i = 1'b0;
    logic [31:0] npc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = 32'd0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = 32'd0;
    logic        flush_i = 1'b0;
`ifdef BTB_STATS_EN
    logic [31:0] lookups_o;
    logic [31:0] hits_o;
`endif

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc_i         (pc_i),
        .lookup_en_i  (lookup_en_i),
        .npc_o        (npc_o),
        .pred_taken_o (pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .flush_i      (flush_i)
`ifdef BTB_STATS_EN
        ,
        .lookups_o    (lookups_o),
        .hits_o       (hits_o)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] npc;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] lk;
        logic [31:0] ht;
        int          step_no;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    // Reference model: a table of entries indexed by word address modulo ENTRIES.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_lk, m_ht;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (2 + IDXW);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_lk = 0; m_ht = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int sn);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", name, sn, act, req);
        end
    endtask

    // Monitor: one comparison set per cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("npc", npc_o, e.npc, e.step_no);
                check("pred_taken", {31'd0, pred_taken_o}, {31'd0, e.taken}, e.step_no);
                check("pred_target", pred_target_o, e.tgt, e.step_no);
`ifdef BTB_STATS_EN
                check("lookups", lookups_o, e.lk, e.step_no);
                check("hits", hits_o, e.ht, e.step_no);
`endif
                $display("step %0d pc=0x%08h npc=0x%08h taken=%0b tgt=0x%08h", e.step_no, pc_i, npc_o, pred_taken_o, pred_target_o);
            end
        end
    end

    // Called just after a rising edge: drive inputs, predict, then advance the model across the next edge.
    task automatic step(input logic [31:0] pc, input logic len, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic fl);
        exp_t e;
        int unsigned i;
        bit hit;
        pc_i = pc; lookup_en_i = len; upd_valid_i = uv; upd_pc_i = upc;
        upd_taken_i = ut; upd_target_i = utgt; flush_i = fl;
        if (!nRST) model_reset();
        i = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        e.taken = hit && (m_ctr[i] >= 2);
        e.tgt = hit ? m_tgt[i] : 32'd0;
        e.npc = e.taken ? m_tgt[i] : pc + 32'd4;
        e.lk = m_lk; e.ht = m_ht;
        e.step_no = step_cnt++;
        exp_q.push_back(e);
        if (nRST) begin
            if (len) begin
                m_lk = m_lk + 1;
                if (hit) m_ht = m_ht + 1;
            end
            if (fl) begin
                for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
            end else if (uv) begin
                i = idx_of(upc);
                if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
                    if (ut) begin
                        m_tgt[i] = utgt;
                        if (m_ctr[i] < 3) m_ctr[i]++;
                    end else if (m_ctr[i] > 0) m_ctr[i]--;
                end else if (ut) begin
                    m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt; m_ctr[i] = 2;
                end
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] rpc, rupc;
        model_reset();
        @(posedge CLK); #1;
        // Reset state
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0);
        nRST = 1'b1;
        // Allocation and counter hysteresis
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0);
        step(32'h40, 1, 0, 0, 0, 0, 0);
        step(32'h40, 1, 1, 32'h40, 0, 0, 0);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0);
        repeat (3) step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0);
        step(32'h40, 1, 0, 0, 0, 0, 0);
        // Aliasing on index 0
        step(32'h80, 1, 1, 32'h80, 1, 32'h200, 0);
        step(32'h40, 1, 0, 0, 0, 0, 0);
        step(32'h80, 1, 0, 0, 0, 0, 0);
        // Flush beats same-cycle update; not-taken miss does not allocate
        step(32'h80, 1, 1, 32'h40, 1, 32'h300, 1);
        step(32'h40, 1, 0, 0, 0, 0, 0);
        step(32'h80, 1, 1, 32'h40, 0, 32'h500, 0);
        step(32'h40, 1, 0, 0, 0, 0, 0);
        // Wrap of pc+4
        step(32'hFFFFFFFC, 1, 0, 0, 0, 0, 0);
        // Randomised traffic over a small address pool to provoke hits and aliasing
        for (int n = 0; n < 400; n++) begin
            rpc  = ($urandom_range(0, 3) << 28) | ($urandom_range(0, 31) << 2);
            rupc = ($urandom_range(0, 3) << 28) | ($urandom_range(0, 31) << 2);
            if (n == 200) nRST = 1'b0;
            if (n == 201) nRST = 1'b1;
            step(rpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rupc,
                 1'($urandom_range(0, 2) != 0), $urandom & 32'hFFFFFFFC,
                 1'($urandom_range(0, 39) == 0));
        end
        // Final asynchronous reset pulse mid-cycle
        nRST = 1'b0;
        step(rpc, 1, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        step(rpc, 1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
